// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_reg
//  Purpose  : Parametrised universal shift register with a multi-step burst
//             engine. Single-cycle ops (hold, SHL, SHR, ROL, ROR, ASR, load,
//             clear) plus a burst mode that repeats one shift/rotate op
//             'amount' times, one step per clock, with a busy/done handshake.
//  Ports    : clk     - clock, rising edge
//             rst     - asynchronous reset, active-low
//             en      - single-step enable (ignored while busy)
//             mode    - op select (000 hold .. 111 clear)
//             sin_l   - serial in, enters bit 0 on shift-left
//             sin_r   - serial in, enters bit WIDTH-1 on logical shift-right
//             pload   - parallel load data (mode 110)
//             start   - burst request, sampled when not busy
//             amount  - burst step count
//             out     - register contents
//             sout_l  - out[WIDTH-1]
//             sout_r  - out[0]
//             busy    - burst in progress
//             done    - one-cycle pulse after the final burst step
//  Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pload,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_ROL   = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ASR   = 3'b101;
  localparam logic [2:0] M_LOAD  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       mode_q,  mode_d;
  logic             done_q,  done_d;

  logic             w_burst_ok;

  // Next register value for one application of an op.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      M_HOLD:  r = v;
      M_SHL:   r = {v[WIDTH-2:0], sl};
      M_SHR:   r = {sr, v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_LOAD:  r = ld;
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the shift/rotate ops may be bursted; anything else falls back to a
  // plain single step under en.
  assign w_burst_ok = start && (amount != '0) && (mode >= M_SHL) && (mode <= M_ASR);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_burst_ok) begin
          // Acceptance edge: the register itself is left untouched.
          mode_d  = mode;
          cnt_d   = amount;
          state_d = RUN;
        end else if (en) begin
          out_d = apply_op(mode, out_q, sin_l, sin_r, pload);
        end
      end
      RUN: begin
        out_d = apply_op(mode_q, out_q, sin_l, sin_r, pload);
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= M_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign out    = out_q;
  assign sout_l = out_q[WIDTH-1];
  assign sout_r = out_q[0];
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule
`default_nettype wire
